eq_sample_scheduler: RTL and testbench
======================================

// Module: eq_sample_scheduler
// PURPOSE
//  Sequences the 8-band equalizer `filter` datapath at the audio sample rate.
//  Opens one filter slot every CYCLES_PER_SAMPLE clocks and drives clk_enable, filter_in and amplifier_gains.
//  Applies gain updates only at sample boundaries and captures filter_out OUT_LATENCY clocks after each issue.
//  Sits between the audio stream source/sink (valid/ready) and the `filter` instance.
// PARAMETERS
//  DATA_BITS          16      sample width (filter_in / filter_out / in_data / out_data)
//  NUMBER_OF_FILTERS  8       equalizer bands
//  GAIN_BITS          2       gain code width per band
//  CYCLES_PER_SAMPLE  64      clocks per sample slot; >= 2
//  OUT_LATENCY        64      clocks from issue to valid filter_out; 1..CYCLES_PER_SAMPLE
//  GAIN_RESET         16'h5555  amplifier_gains value after reset (code 01 in every band)
// PORTS
//  clk               in   1    system clock
//  rst               in   1    asynchronous reset, active-low
//  run_enable        in   1    1 = schedule samples; 0 = finish current slot, drain, stop
//  in_data           in   DATA_BITS  input audio sample (signed)
//  in_valid          in   1    in_data valid
//  in_ready          out  1    input buffer can accept a sample
//  gains_in          in   NUMBER_OF_FILTERS*GAIN_BITS  requested band gains
//  gains_valid       in   1    gain update request
//  gains_ack         out  1    1-clk pulse when the requested gains reach amplifier_gains
//  amp_enable_in     in   1    requested amplifier enable, sampled at slot start
//  filter_clk_enable out  1    to filter.clk_enable
//  filter_in         out  DATA_BITS  to filter.filter_in
//  amplifier_enable  out  1    to filter.amplifier_enable
//  amplifier_gains   out  NUMBER_OF_FILTERS*GAIN_BITS  to filter.amplifier_gains
//  filter_out        in   DATA_BITS  from filter.filter_out
//  out_data          out  DATA_BITS  filtered sample
//  out_valid         out  1    out_data valid; held until out_ready
//  out_ready         in   1    sink accepts out_data
//  underrun          out  1    sticky: a slot started with an empty input buffer
//  overrun           out  1    sticky: a result overwrote an unaccepted out_data
//  busy              out  1    state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, slot counter 0.
//   Outputs: filter_clk_enable=0, filter_in=0, amplifier_gains=GAIN_RESET, amplifier_enable=1.
//   Outputs: out_data=0, out_valid=0, gains_ack=0, underrun=0, overrun=0.
//   Input buffer and gain shadow are cleared; in_ready=1 after reset release.
//  Input buffer: 1 entry; in_ready = !buf_full; write on in_valid&in_ready; freed at slot start.
//   A write and a free in the same clk leave the buffer full with the new sample.
//  FSM IDLE: filter_clk_enable=0, counter held at 0.
//   Gain shadow is applied directly (amplifier_gains updated, gains_ack pulses next clk).
//   -> RUN when run_enable=1 && buf_full.
//  FSM RUN: filter_clk_enable=1; counter 0..CYCLES_PER_SAMPLE-1 and wraps.
//   At counter==0 (slot start), filter_in <= buffer, or 0 with underrun<=1 if the buffer is empty.
//   Also at slot start: shadow gains and amp_enable_in are applied, and gains_ack pulses if the shadow was pending.
//   filter_in and amplifier_gains are held constant for the whole slot.
//   At counter==CYCLES_PER_SAMPLE-1: if run_enable=0 -> DRAIN.
//  FSM DRAIN: filter_clk_enable=1, no new issue.
//   -> IDLE once the final result is captured; counter is then reset to 0.
//  Capture: a down-timer loaded with OUT_LATENCY at each issue.
//   At expiry, out_data<=filter_out and out_valid<=1.
//   If out_valid&&!out_ready at capture: overwrite and set overrun<=1.
//   out_valid clears on out_ready unless a capture occurs in the same clk.
//   With OUT_LATENCY==CYCLES_PER_SAMPLE, capture of sample k coincides with issue of k+1 (both occur).
//  Gains: gains_valid latches gains_in into the shadow when no update is pending.
//   While an update is pending, gains_valid is ignored; the source holds its request until gains_ack.
//  Sticky flags clear only on reset.
//  run_enable toggled mid-slot has effect only at the slot end; reset mid-slot aborts immediately.
// TESTING
//  T1 reset: rst=0 mid-RUN -> next clk all outputs at reset values, busy=0, amplifier_gains=16'h5555.
//  T2 impulse: in_data 16'h7fff then zeros, run_enable=1.
//   -> one issue per 64 clk, out_valid 64 clk after each issue.
//   -> out_data == filter_out sampled at that clk.
//  T3 gain update mid-slot: gains_valid with 16'hFFFF at counter=10.
//   -> amplifier_gains unchanged until counter==0, then 16'hFFFF, gains_ack 1 clk.
//  T4 underrun: source idle for one slot -> filter_in=0 for that slot, underrun=1 stays set.
//  T5 overrun: out_ready=0 for two captures -> second out_data replaces first, overrun=1.
//  T6 stop: run_enable=0 at counter=20 -> slot completes, DRAIN until final capture.
//   -> then IDLE, filter_clk_enable=0, busy=0.

Source files
------------

// File: rtl/eq_sample_scheduler.sv
// Sample-rate sequencer for the 8-band equalizer filter: issues one sample per slot,
// applies gain updates at slot boundaries and captures the filter result after a fixed latency.
module eq_sample_scheduler #(
    parameter int unsigned DATA_BITS         = 16,
    parameter int unsigned NUMBER_OF_FILTERS = 8,
    parameter int unsigned GAIN_BITS         = 2,
    parameter int unsigned CYCLES_PER_SAMPLE = 64,
    parameter int unsigned OUT_LATENCY       = 64,
    parameter logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] GAIN_RESET = 16'h5555
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   run_enable,
    input  logic [DATA_BITS-1:0]                   in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] gains_in,
    input  logic                                   gains_valid,
    output logic                                   gains_ack,
    input  logic                                   amp_enable_in,
    output logic                                   filter_clk_enable,
    output logic [DATA_BITS-1:0]                   filter_in,
    output logic                                   amplifier_enable,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
    input  logic [DATA_BITS-1:0]                   filter_out,
    output logic [DATA_BITS-1:0]                   out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   underrun,
    output logic                                   overrun,
    output logic                                   busy
);

    localparam int unsigned GainW = NUMBER_OF_FILTERS * GAIN_BITS;
    localparam int unsigned CntW  = $clog2(CYCLES_PER_SAMPLE);
    localparam int unsigned TmrW  = $clog2(OUT_LATENCY + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CYCLES_PER_SAMPLE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [TmrW-1:0]     tmr_q;
    logic                buf_full_q;
    logic [DATA_BITS-1:0] buf_data_q;
    logic [GainW-1:0]    shadow_q, gains_q;
    logic                pending_q, ack_q, amp_en_q;
    logic [DATA_BITS-1:0] fin_q, out_data_q;
    logic                out_valid_q, underrun_q, overrun_q;

    logic slot_start, capture, apply_gains, buf_wr, gains_take;

    assign slot_start  = (state_q == StRun) && (cnt_q == '0);
    assign capture     = (tmr_q == TmrW'(1));
    assign apply_gains = pending_q && ((state_q == StIdle) || slot_start);
    assign buf_wr      = in_valid && !buf_full_q;
    // The ack cycle is also blocked so a source still holding its request is not re-latched.
    assign gains_take  = gains_valid && !pending_q && !ack_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (run_enable && buf_full_q) state_d = StRun;
            end
            StRun: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (!run_enable) state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                cnt_d = '0;
                // Leave on the final capture, or at once if it already happened in the slot.
                if (tmr_q <= TmrW'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            fin_q      <= '0;
            tmr_q      <= '0;
            underrun_q <= 1'b0;
            amp_en_q   <= 1'b1;
        end else begin
            if (buf_wr) begin
                buf_full_q <= 1'b1;
                buf_data_q <= in_data;
            end else if (slot_start) begin
                buf_full_q <= 1'b0;
            end
            if (slot_start) begin
                fin_q    <= buf_full_q ? buf_data_q : '0;
                tmr_q    <= TmrW'(OUT_LATENCY);
                amp_en_q <= amp_enable_in;
                if (!buf_full_q) underrun_q <= 1'b1;
            end else if (tmr_q != '0) begin
                tmr_q <= tmr_q - TmrW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q  <= '0;
            gains_q   <= GAIN_RESET;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= apply_gains;
            if (apply_gains) begin
                gains_q   <= shadow_q;
                pending_q <= 1'b0;
            end else if (gains_take) begin
                shadow_q  <= gains_in;
                pending_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (capture) begin
            out_data_q  <= filter_out;
            out_valid_q <= 1'b1;
            if (out_valid_q && !out_ready) overrun_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready          = !buf_full_q;
    assign gains_ack         = ack_q;
    assign filter_clk_enable = (state_q != StIdle);
    assign filter_in         = fin_q;
    assign amplifier_enable  = amp_en_q;
    assign amplifier_gains   = gains_q;
    assign out_data          = out_data_q;
    assign out_valid         = out_valid_q;
    assign underrun          = underrun_q;
    assign overrun           = overrun_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_eq_sample_scheduler.sv
// Bench for eq_sample_scheduler: slot timing, gain handoff, underrun/overrun and stop,
// with expected values from slot arithmetic (issue every 64 clk, capture 64 clk after issue).
module tb_eq_sample_scheduler;

    localparam int unsigned C = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_enable;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] gains_in;
    logic        gains_valid;
    logic        gains_ack;
    logic        amp_enable_in;
    logic        filter_clk_enable;
    logic [15:0] filter_in;
    logic        amplifier_enable;
    logic [15:0] amplifier_gains;
    logic [15:0] filter_out;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        underrun;
    logic        overrun;
    logic        busy;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    eq_sample_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .run_enable       (run_enable),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .gains_in         (gains_in),
        .gains_valid      (gains_valid),
        .gains_ack        (gains_ack),
        .amp_enable_in    (amp_enable_in),
        .filter_clk_enable(filter_clk_enable),
        .filter_in        (filter_in),
        .amplifier_enable (amplifier_enable),
        .amplifier_gains  (amplifier_gains),
        .filter_out       (filter_out),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .underrun         (underrun),
        .overrun          (overrun),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the filter: a fresh random result every cycle, stable across each posedge.
    initial begin
        filter_out = '0;
        forever begin
            @(negedge clk);
            filter_out = 16'($urandom);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit push, input logic [15:0] d);
        in_valid = push;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; run_enable = 1'b0; in_valid = 1'b0; in_data = '0;
        gains_valid = 1'b0; gains_in = '0; amp_enable_in = 1'b1; out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // Returns just after the first issue edge: write, IDLE->RUN, issue.
    task automatic start_run(input logic [15:0] d);
        run_enable = 1'b1;
        step(1'b1, d);
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] s;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            if (p == 1) begin
                gains_valid = 1'b1; gains_in = 16'hA0F3;
                tick(); tick();
                gains_valid = 1'b0;
                amp_enable_in = 1'b0; out_ready = 1'b0;
                s = 16'($urandom) | 16'h0001;
                start_run(s);
                for (int j = 1; j <= C; j++) step(1'b0, '0);
                n_chk++; if (underrun !== 1'b1) $display("FAIL reset.pre_underrun got %0b want 1", underrun); else n_pass++;
                n_chk++; if (amplifier_gains !== 16'hA0F3) $display("FAIL reset.pre_gains got %h want a0f3", amplifier_gains); else n_pass++;
                #3 rst = 1'b0;
                #1;
            end
            n_chk++; if (filter_clk_enable !== 1'b0) $display("FAIL reset%0d.clk_en got %0b want 0", p, filter_clk_enable); else n_pass++;
            n_chk++; if (filter_in !== 16'h0) $display("FAIL reset%0d.filter_in got %h want 0", p, filter_in); else n_pass++;
            n_chk++; if (amplifier_gains !== 16'h5555) $display("FAIL reset%0d.gains got %h want 5555", p, amplifier_gains); else n_pass++;
            n_chk++; if (amplifier_enable !== 1'b1) $display("FAIL reset%0d.amp_en got %0b want 1", p, amplifier_enable); else n_pass++;
            n_chk++; if (out_data !== 16'h0) $display("FAIL reset%0d.out_data got %h want 0", p, out_data); else n_pass++;
            n_chk++; if (out_valid !== 1'b0) $display("FAIL reset%0d.out_valid got %0b want 0", p, out_valid); else n_pass++;
            n_chk++; if (gains_ack !== 1'b0) $display("FAIL reset%0d.gains_ack got %0b want 0", p, gains_ack); else n_pass++;
            n_chk++; if (underrun !== 1'b0) $display("FAIL reset%0d.underrun got %0b want 0", p, underrun); else n_pass++;
            n_chk++; if (overrun !== 1'b0) $display("FAIL reset%0d.overrun got %0b want 0", p, overrun); else n_pass++;
            n_chk++; if (busy !== 1'b0) $display("FAIL reset%0d.busy got %0b want 0", p, busy); else n_pass++;
            n_chk++; if (in_ready !== 1'b1) $display("FAIL reset%0d.in_ready got %0b want 1", p, in_ready); else n_pass++;
            if (p == 1) begin
                tick();
                rst = 1'b1;
                tick();
            end
        end
    endtask

    task automatic test_impulse();
        logic [15:0] cur, nxt;
        int unsigned off, pulses;
        do_reset();
        cur = 16'h7fff;
        start_run(cur);
        n_chk++; if (filter_in !== cur) $display("FAIL impulse.first_issue got %h want %h", filter_in, cur); else n_pass++;
        n_chk++; if (busy !== 1'b1 || filter_clk_enable !== 1'b1) $display("FAIL impulse.running got %0b%0b want 11", busy, filter_clk_enable); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            nxt = (k == 0) ? 16'h0000 : 16'($urandom);
            off = $urandom_range(1, 60);
            pulses = 0;
            for (int j = 1; j <= C; j++) begin
                step(j == off, nxt);
                if (out_valid === 1'b1) pulses++;
                if (j == int'(off)) begin
                    n_chk++; if (in_ready !== 1'b0) $display("FAIL impulse.buf_full got %0b want 0", in_ready); else n_pass++;
                end
                if (j == C - 1) begin
                    n_chk++; if (filter_in !== cur) $display("FAIL impulse.hold%0d got %h want %h", k, filter_in, cur); else n_pass++;
                    n_chk++; if (out_valid !== 1'b0) $display("FAIL impulse.early_valid%0d got %0b want 0", k, out_valid); else n_pass++;
                end
            end
            n_chk++; if (filter_in !== nxt) $display("FAIL impulse.issue%0d got %h want %h", k, filter_in, nxt); else n_pass++;
            n_chk++; if (out_valid !== 1'b1) $display("FAIL impulse.valid%0d got %0b want 1", k, out_valid); else n_pass++;
            n_chk++; if (out_data !== filter_out) $display("FAIL impulse.data%0d got %h want %h", k, out_data, filter_out); else n_pass++;
            n_chk++; if (pulses != 1) $display("FAIL impulse.pulses%0d got %0d want 1", k, pulses); else n_pass++;
            cur = nxt;
        end
        n_chk++; if (underrun !== 1'b0 || overrun !== 1'b0) $display("FAIL impulse.flags got %0b%0b want 00", underrun, overrun); else n_pass++;
    endtask

    task automatic test_gain_update();
        logic [15:0] gcur, gn;
        logic amp_cur, amp_new;
        int unsigned acks;
        do_reset();
        gcur = 16'($urandom & 32'hFFFE) | 16'h8000;
        gains_valid = 1'b1; gains_in = gcur;
        tick();
        n_chk++; if (amplifier_gains !== 16'h5555 || gains_ack !== 1'b0) $display("FAIL gains.idle_latch got %h/%0b want 5555/0", amplifier_gains, gains_ack); else n_pass++;
        tick();
        n_chk++; if (amplifier_gains !== gcur || gains_ack !== 1'b1) $display("FAIL gains.idle_apply got %h/%0b want %h/1", amplifier_gains, gains_ack, gcur); else n_pass++;
        gains_valid = 1'b0;
        tick();
        n_chk++; if (gains_ack !== 1'b0 || amplifier_gains !== gcur) $display("FAIL gains.idle_ack_end got %0b/%h want 0/%h", gains_ack, amplifier_gains, gcur); else n_pass++;
        amp_cur = 1'b1;
        start_run(16'($urandom));
        for (int it = 0; it < 2; it++) begin
            gn = (it == 0) ? 16'hFFFF : 16'($urandom & 32'h7FFF);
            amp_new = ~amp_cur;
            acks = 0;
            for (int j = 1; j <= C; j++) begin
                if (j == 11) begin gains_valid = 1'b1; gains_in = gn; end
                if (j == 13) gains_in = ~gn;
                if (j == 30) amp_enable_in = amp_new;
                step(j == 5, 16'($urandom));
                if (gains_ack === 1'b1) acks++;
                if (j == 1 && it > 0) begin
                    n_chk++; if (gains_ack !== 1'b0) $display("FAIL gains.ack_width got %0b want 0", gains_ack); else n_pass++;
                end
                if (j == C - 1) begin
                    n_chk++; if (amplifier_gains !== gcur) $display("FAIL gains.hold%0d got %h want %h", it, amplifier_gains, gcur); else n_pass++;
                    n_chk++; if (amplifier_enable !== amp_cur) $display("FAIL gains.amp_hold%0d got %0b want %0b", it, amplifier_enable, amp_cur); else n_pass++;
                end
            end
            n_chk++; if (amplifier_gains !== gn) $display("FAIL gains.apply%0d got %h want %h", it, amplifier_gains, gn); else n_pass++;
            n_chk++; if (gains_ack !== 1'b1 || acks != 1) $display("FAIL gains.ack%0d got %0b/%0d want 1/1", it, gains_ack, acks); else n_pass++;
            n_chk++; if (amplifier_enable !== amp_new) $display("FAIL gains.amp_apply%0d got %0b want %0b", it, amplifier_enable, amp_new); else n_pass++;
            gains_valid = 1'b0;
            gcur = gn;
            amp_cur = amp_new;
        end
        tick();
        n_chk++; if (gains_ack !== 1'b0 || amplifier_gains !== gcur) $display("FAIL gains.final got %0b/%h want 0/%h", gains_ack, amplifier_gains, gcur); else n_pass++;
    endtask

    task automatic test_underrun();
        logic [15:0] s2;
        int unsigned off;
        do_reset();
        start_run(16'($urandom) | 16'h0001);
        for (int j = 1; j <= C; j++) begin
            step(1'b0, '0);
            if (j == C - 1) begin
                n_chk++; if (underrun !== 1'b0) $display("FAIL underrun.early got %0b want 0", underrun); else n_pass++;
            end
        end
        n_chk++; if (filter_in !== 16'h0) $display("FAIL underrun.zero_issue got %h want 0", filter_in); else n_pass++;
        n_chk++; if (underrun !== 1'b1) $display("FAIL underrun.set got %0b want 1", underrun); else n_pass++;
        s2 = 16'($urandom) | 16'h0001;
        off = $urandom_range(1, 60);
        for (int j = 1; j <= C; j++) step(j == off, s2);
        n_chk++; if (filter_in !== s2) $display("FAIL underrun.recover got %h want %h", filter_in, s2); else n_pass++;
        n_chk++; if (underrun !== 1'b1) $display("FAIL underrun.sticky got %0b want 1", underrun); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [15:0] fo1, fo2;
        do_reset();
        out_ready = 1'b0;
        start_run(16'($urandom));
        for (int j = 1; j <= C; j++) step(j == 7, 16'($urandom));
        fo1 = filter_out;
        n_chk++; if (out_valid !== 1'b1 || out_data !== fo1) $display("FAIL overrun.first got %0b/%h want 1/%h", out_valid, out_data, fo1); else n_pass++;
        n_chk++; if (overrun !== 1'b0) $display("FAIL overrun.early got %0b want 0", overrun); else n_pass++;
        for (int j = 1; j <= C; j++) begin
            step(j == 7, 16'($urandom));
            if (j == C - 1) begin
                n_chk++; if (out_valid !== 1'b1 || out_data !== fo1) $display("FAIL overrun.held got %0b/%h want 1/%h", out_valid, out_data, fo1); else n_pass++;
            end
        end
        fo2 = filter_out;
        n_chk++; if (out_data !== fo2) $display("FAIL overrun.replace got %h want %h", out_data, fo2); else n_pass++;
        n_chk++; if (overrun !== 1'b1) $display("FAIL overrun.set got %0b want 1", overrun); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_chk++; if (out_valid !== 1'b0 || overrun !== 1'b1) $display("FAIL overrun.accept got %0b/%0b want 0/1", out_valid, overrun); else n_pass++;
    endtask

    task automatic test_stop();
        logic [15:0] s1;
        do_reset();
        start_run(16'($urandom));
        s1 = 16'($urandom);
        for (int j = 1; j <= C; j++) step(j == 9, s1);
        for (int j = 1; j <= C; j++) begin
            if (j == 21) run_enable = 1'b0;
            step(j == 40, 16'($urandom));
            if (j == C - 1) begin
                n_chk++; if (busy !== 1'b1 || filter_clk_enable !== 1'b1) $display("FAIL stop.drain got %0b%0b want 11", busy, filter_clk_enable); else n_pass++;
            end
        end
        n_chk++; if (busy !== 1'b0 || filter_clk_enable !== 1'b0) $display("FAIL stop.idle got %0b%0b want 00", busy, filter_clk_enable); else n_pass++;
        n_chk++; if (out_valid !== 1'b1 || out_data !== filter_out) $display("FAIL stop.final_capture got %0b/%h want 1/%h", out_valid, out_data, filter_out); else n_pass++;
        n_chk++; if (filter_in !== s1 || in_ready !== 1'b0) $display("FAIL stop.no_issue got %h/%0b want %h/0", filter_in, in_ready, s1); else n_pass++;
        repeat (3) tick();
        n_chk++; if (busy !== 1'b0 || filter_clk_enable !== 1'b0) $display("FAIL stop.stays_idle got %0b%0b want 00", busy, filter_clk_enable); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_gain_update();
        test_underrun();
        test_overrun();
        test_stop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
